// File: rtl/gp01_acc_arbiter_if.sv
// Command/result bundle for gp01_acc_arbiter: two requester command ports
// and one valid/ready result port.
interface gp01_acc_arbiter_if #(
  parameter int DATA_W = 3,
  parameter int ACC_W  = 6,
  parameter int LEN_W  = 4
);
  logic              i_a_valid;
  logic              o_a_ready;
  logic [DATA_W-1:0] i_a_data1;
  logic [DATA_W-1:0] i_a_data2;
  logic [1:0]        i_a_sel;
  logic [LEN_W-1:0]  i_a_len;

  logic              i_b_valid;
  logic              o_b_ready;
  logic [DATA_W-1:0] i_b_data1;
  logic [DATA_W-1:0] i_b_data2;
  logic [1:0]        i_b_sel;
  logic [LEN_W-1:0]  i_b_len;

  logic              o_res_valid;
  logic              i_res_ready;
  logic [ACC_W-1:0]  o_res_data;
  logic              o_res_ovf;
  logic              o_res_id;
  logic              o_busy;

  modport slave (
    input  i_a_valid, i_a_data1, i_a_data2, i_a_sel, i_a_len,
    input  i_b_valid, i_b_data1, i_b_data2, i_b_sel, i_b_len,
    input  i_res_ready,
    output o_a_ready, o_b_ready,
    output o_res_valid, o_res_data, o_res_ovf, o_res_id, o_busy
  );

  modport master (
    output i_a_valid, i_a_data1, i_a_data2, i_a_sel, i_a_len,
    output i_b_valid, i_b_data1, i_b_data2, i_b_sel, i_b_len,
    output i_res_ready,
    input  o_a_ready, o_b_ready,
    input  o_res_valid, o_res_data, o_res_ovf, o_res_id, o_busy
  );
endinterface

// File: rtl/gp01_acc_arbiter.sv
// Round-robin arbiter in front of a shared mux/accumulate datapath; each
// granted burst sums len selected terms and returns sum plus sticky carry.
module gp01_acc_arbiter #(
  parameter int DATA_W = 3,
  parameter int ACC_W  = 6,
  parameter int LEN_W  = 4
) (
  input logic clk,
  input logic i_rst_n,
  gp01_acc_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESULT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] d1_q, d2_q;
  logic [1:0]        sel_q;
  logic              id_q;
  logic              last_b;
  logic              grant_a, grant_b;
  logic              a_ready, b_ready;
  logic [LEN_W-1:0]  len_in;
  logic [ACC_W:0]    sum;

  function automatic logic [ACC_W:0] term_f(input logic [DATA_W-1:0] d1,
                                            input logic [DATA_W-1:0] d2,
                                            input logic [1:0]        sel);
    case (sel)
      2'b00:   term_f = (ACC_W+1)'(d2);
      2'b01:   term_f = (ACC_W+1)'(d1) + (ACC_W+1)'(d2);
      2'b10:   term_f = (ACC_W+1)'(d1);
      default: term_f = '0;
    endcase
  endfunction

  // Contention goes to whoever did not win last; last_b resets high so A wins first.
  assign grant_a = bus.i_a_valid && (!bus.i_b_valid || last_b);
  assign grant_b = bus.i_b_valid && !grant_a;
  assign len_in  = grant_b ? bus.i_b_len : bus.i_a_len;
  assign sum     = {1'b0, acc} + term_f(d1_q, d2_q, sel_q);

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    case (state)
      IDLE: begin
        a_ready = grant_a;
        b_ready = grant_b;
        if (grant_a || grant_b)
          state_nxt = (len_in != '0) ? RUN : RESULT;
      end
      RUN:     if (count == LEN_W'(1)) state_nxt = RESULT;
      RESULT:  if (bus.i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      ovf    <= 1'b0;
      count  <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      sel_q  <= '0;
      id_q   <= 1'b0;
      last_b <= 1'b1;
    end else begin
      state <= state_nxt;
      if (a_ready || b_ready) begin
        d1_q   <= grant_b ? bus.i_b_data1 : bus.i_a_data1;
        d2_q   <= grant_b ? bus.i_b_data2 : bus.i_a_data2;
        sel_q  <= grant_b ? bus.i_b_sel   : bus.i_a_sel;
        id_q   <= b_ready;
        last_b <= b_ready;
        acc    <= '0;
        ovf    <= 1'b0;
        count  <= len_in;
      end else if (state == RUN) begin
        acc   <= sum[ACC_W-1:0];
        ovf   <= ovf | sum[ACC_W];
        count <= count - LEN_W'(1);
      end
    end
  end

  assign bus.o_a_ready   = a_ready;
  assign bus.o_b_ready   = b_ready;
  assign bus.o_res_valid = (state == RESULT);
  assign bus.o_res_data  = acc;
  assign bus.o_res_ovf   = ovf;
  assign bus.o_res_id    = id_q;
  assign bus.o_busy      = (state != IDLE);
endmodule

// File: tb/tb_gp01_acc_arbiter.sv
// Randomized bench for gp01_acc_arbiter against a transaction-level model
// (round-robin grant, arithmetic burst sum, carry = total reaching 2^ACC_W).
module tb_gp01_acc_arbiter;
  localparam int DATA_W = 3;
  localparam int ACC_W  = 6;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gp01_acc_arbiter_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  gp01_acc_arbiter #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit last_b   = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int term(input int d1, input int d2, input int sel);
    case (sel)
      0:       return d2;
      1:       return d1 + d2;
      2:       return d1;
      default: return 0;
    endcase
  endfunction

  task automatic scramble();
    bus.i_a_valid = 1'($urandom);
    bus.i_b_valid = 1'($urandom);
    bus.i_a_data1 = 3'($urandom);
    bus.i_a_data2 = 3'($urandom);
    bus.i_a_sel   = 2'($urandom);
    bus.i_a_len   = 4'($urandom);
    bus.i_b_data1 = 3'($urandom);
    bus.i_b_data2 = 3'($urandom);
    bus.i_b_sel   = 2'($urandom);
    bus.i_b_len   = 4'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.o_res_valid, 0);
    check({tag, "_data"},  bus.o_res_data, 0);
    check({tag, "_ovf"},   bus.o_res_ovf, 0);
    check({tag, "_id"},    bus.o_res_id, 0);
    check({tag, "_busy"},  bus.o_busy, 0);
    check({tag, "_ready"}, {bus.o_a_ready, bus.o_b_ready}, 0);
  endtask

  // Called and returns shortly after a rising edge with the DUT idle.
  task automatic run_txn(input bit va, input bit vb,
                         input int a1, input int a2, input int as, input int al,
                         input int b1, input int b2, input int bs, input int bl,
                         input int bp);
    bit ga, gb;
    int d1, d2, s, l, tot, lat;
    bus.i_a_valid = va;  bus.i_b_valid = vb;
    bus.i_a_data1 = 3'(a1); bus.i_a_data2 = 3'(a2); bus.i_a_sel = 2'(as); bus.i_a_len = 4'(al);
    bus.i_b_data1 = 3'(b1); bus.i_b_data2 = 3'(b2); bus.i_b_sel = 2'(bs); bus.i_b_len = 4'(bl);
    bus.i_res_ready = 1'b0;
    #1;
    ga = va && (!vb || last_b);
    gb = vb && !ga;
    check("a_ready", bus.o_a_ready, ga);
    check("b_ready", bus.o_b_ready, gb);
    check("busy_idle", bus.o_busy, 0);
    @(posedge clk); #1;
    if (!(ga || gb)) begin
      bus.i_a_valid = 1'b0; bus.i_b_valid = 1'b0;
      return;
    end
    last_b = gb;
    d1 = gb ? b1 : a1; d2 = gb ? b2 : a2; s = gb ? bs : as; l = gb ? bl : al;
    tot = l * term(d1, d2, s);
    lat = 0;
    while (!bus.o_res_valid && lat < 40) begin
      scramble(); #1;
      check("ready_run", {bus.o_a_ready, bus.o_b_ready}, 0);
      check("busy_run", bus.o_busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, l);
    check("res_data", bus.o_res_data, tot % 64);
    check("res_ovf", bus.o_res_ovf, (tot >= 64));
    check("res_id", bus.o_res_id, gb);
    for (int i = 0; i < bp; i++) begin
      scramble(); #1;
      check("ready_hold", {bus.o_a_ready, bus.o_b_ready}, 0);
      @(posedge clk); #1;
      check("hold_valid", bus.o_res_valid, 1);
      check("hold_data", bus.o_res_data, tot % 64);
      check("hold_ovf", bus.o_res_ovf, (tot >= 64));
      check("hold_id", bus.o_res_id, gb);
    end
    bus.i_a_valid = 1'b0; bus.i_b_valid = 1'b0;
    bus.i_res_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_res_ready = 1'b0;
    check("ret_valid", bus.o_res_valid, 0);
    check("ret_busy", bus.o_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_a_valid = 1'b0; bus.i_b_valid = 1'b0; bus.i_res_ready = 1'b0;
    bus.i_a_data1 = '0; bus.i_a_data2 = '0; bus.i_a_sel = '0; bus.i_a_len = '0;
    bus.i_b_data1 = '0; bus.i_b_data2 = '0; bus.i_b_sel = '0; bus.i_b_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan
    run_txn(1, 0, 3, 2, 1, 4, 0, 0, 0, 0, 0);   // 20
    run_txn(0, 1, 0, 0, 0, 0, 7, 7, 1, 5, 0);   // 70 -> 6, ovf
    run_txn(1, 0, 5, 0, 2, 3, 0, 0, 0, 0, 0);   // 15
    run_txn(0, 1, 0, 0, 0, 0, 0, 4, 0, 2, 0);   // 8
    run_txn(1, 0, 6, 6, 3, 7, 0, 0, 0, 0, 0);   // 0
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 1, 1, 1, 1, 2, 2, 1, 1, 0);
    run_txn(1, 0, 7, 7, 1, 0, 0, 0, 0, 0, 0);   // len 0
    run_txn(0, 1, 0, 0, 0, 0, 3, 4, 1, 9, 10);  // backpressure

    // Abort a burst by reset after its first step
    bus.i_a_valid = 1'b1; bus.i_a_data1 = 3'd1; bus.i_a_data2 = 3'd1;
    bus.i_a_sel = 2'b01; bus.i_a_len = 4'd8; bus.i_b_valid = 1'b0;
    @(posedge clk); #1;
    bus.i_a_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst_n = 1'b1;
    last_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("no_result", bus.o_res_valid, 0);
    end
    run_txn(1, 1, 2, 3, 1, 2, 4, 4, 1, 2, 0);

    // Randomized traffic
    for (int i = 0; i < 250; i++)
      run_txn(1'($urandom), 1'($urandom),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
